// File: rtl/cart_mapper.sv
// Cartridge bank-switch controller: decodes hotspot/bank-register accesses from the
// 6507 bus, forms the ROM byte address and provides the optional 128-byte SuperChip RAM.
module cart_mapper #(
    parameter int ROM_AW   = 15,
    parameter int SC_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [2:0]        mapper,
    input  logic              sc_en,
    input  logic [12:0]       a,
    input  logic              r,
    input  logic [7:0]        d_in,
    input  logic [7:0]        rom_di,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              cart_sel,
    output logic [7:0]        cart_do,
    output logic [2:0]        bank
);

    typedef enum logic [2:0] {
        M_NONE = 3'd0,
        M_F8   = 3'd1,
        M_F6   = 3'd2,
        M_F4   = 3'd3,
        M_E0   = 3'd4,
        M_3F   = 3'd5
    } mapper_t;

    function automatic mapper_t decode_mapper(input logic [2:0] m);
        case (m)
            3'd1:    return M_F8;
            3'd2:    return M_F6;
            3'd3:    return M_F4;
            3'd4:    return M_E0;
            3'd5:    return M_3F;
            default: return M_NONE;
        endcase
    endfunction

    function automatic logic [2:0] reset_bank(input logic [2:0] m);
        case (m)
            3'd1:    return 3'd1;
            3'd2:    return 3'd3;
            3'd3:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    mapper_t     mode_q;
    logic        sc_en_q;
    logic [2:0]  bank_q, bank_d;
    logic [2:0]  s0_q, s1_q, s2_q;
    logic [2:0]  s0_d, s1_d, s2_d;
    logic [2:0]  slice;
    logic [14:0] addr_full;
    logic        sc_active, sc_wr_port, sc_rd_port;
    logic [7:0]  ram [SC_DEPTH];
    logic [7:0]  ram_q;

    // Mapper selection is frozen at reset so a live mapper change cannot corrupt the image.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= decode_mapper(mapper);
            sc_en_q <= sc_en;
            bank_q  <= reset_bank(mapper);
            s0_q    <= 3'd4;
            s1_q    <= 3'd5;
            s2_q    <= 3'd6;
        end else begin
            bank_q <= bank_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end

    always_comb begin
        bank_d = bank_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        if (ce) begin
            case (mode_q)
                M_F8: if (a[12] && a[11:0] >= 12'hFF8 && a[11:0] <= 12'hFF9) bank_d = a[2:0];
                M_F6: if (a[12] && a[11:0] >= 12'hFF6 && a[11:0] <= 12'hFF9) bank_d = a[2:0] - 3'd6;
                M_F4: if (a[12] && a[11:0] >= 12'hFF4 && a[11:0] <= 12'hFFB) bank_d = a[2:0] - 3'd4;
                M_E0: begin
                    if (a[12] && a[11:0] >= 12'hFE0 && a[11:0] <= 12'hFF7) begin
                        case (a[4:3])
                            2'd0:    s0_d = a[2:0];
                            2'd1:    s1_d = a[2:0];
                            default: s2_d = a[2:0];
                        endcase
                    end
                end
                M_3F: if (!r && a[12:6] == 7'd0) bank_d = {1'b0, d_in[1:0]};
                default: ;
            endcase
        end
    end

    always_comb begin
        case (a[11:10])
            2'd0:    slice = s0_q;
            2'd1:    slice = s1_q;
            2'd2:    slice = s2_q;
            default: slice = 3'd7;
        endcase
    end

    always_comb begin
        addr_full = {3'b000, a[11:0]};
        bank      = 3'd0;
        case (mode_q)
            M_F8, M_F6, M_F4: begin
                addr_full = {bank_q, a[11:0]};
                bank      = bank_q;
            end
            M_E0: begin
                addr_full = {2'b00, slice, a[9:0]};
                bank      = s0_q;
            end
            M_3F: begin
                addr_full = a[11] ? {4'b0011, a[10:0]} : {2'b00, bank_q[1:0], a[10:0]};
                bank      = bank_q;
            end
            default: ;
        endcase
    end

    assign rom_addr = ROM_AW'(addr_full);
    assign cart_sel = a[12];

    // SuperChip only exists alongside the F8/F6/F4 schemes.
    assign sc_active  = sc_en_q && (mode_q == M_F8 || mode_q == M_F6 || mode_q == M_F4);
    assign sc_wr_port = (a[12:7] == 6'b100000);
    assign sc_rd_port = (a[12:7] == 6'b100001);

    // RAM is deliberately not reset; the read is registered and settles well before ce.
    always_ff @(posedge clk) begin
        if (!rst && ce && !r && sc_active && sc_wr_port)
            ram[a[6:0]] <= d_in;
        ram_q <= ram[a[6:0]];
    end

    always_comb begin
        if (!a[12])
            cart_do = 8'hFF;
        else if (sc_active && sc_rd_port)
            cart_do = ram_q;
        else
            cart_do = rom_di;
    end

endmodule

// File: tb/tb_cart_mapper.sv
// Bench for cart_mapper: directed vector table, hand sequences for SuperChip/reset
// corners, then random bus traffic checked against an address-arithmetic model.
module tb_cart_mapper;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [2:0]  mapper = 3'd0;
    logic        sc_en = 1'b0;
    logic [12:0] a = 13'd0;
    logic        r = 1'b1;
    logic [7:0]  d_in = 8'd0;
    logic [7:0]  rom_di;
    logic [14:0] rom_addr;
    logic        cart_sel;
    logic [7:0]  cart_do;
    logic [2:0]  bank;

    int errors = 0;
    int checks = 0;

    logic [14:0] s_addr;
    logic [7:0]  s_do;
    logic        s_sel;
    logic [2:0]  s_bank;

    function automatic logic [7:0] rom_f(input logic [14:0] x);
        return x[7:0] ^ {1'b1, x[14:8]};
    endfunction

    assign rom_di = rom_f(rom_addr);

    always #5 clk = ~clk;

    cart_mapper #(.ROM_AW(15), .SC_DEPTH(128)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mapper(mapper), .sc_en(sc_en),
        .a(a), .r(r), .d_in(d_in), .rom_di(rom_di),
        .rom_addr(rom_addr), .cart_sel(cart_sel), .cart_do(cart_do), .bank(bank)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic do_reset(input logic [2:0] mp, input logic sc);
        @(negedge clk);
        ce = 1'b0; rst = 1'b1; mapper = mp; sc_en = sc;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Two-clock CPU cycle: address settles one clk, ce pulses on the second.
    // Combinational outputs sampled just before the ce edge; bank just after.
    task automatic access(input logic [12:0] aa, input logic rr, input logic [7:0] dd, input logic cev);
        @(negedge clk);
        a = aa; r = rr; d_in = dd; ce = 1'b0;
        @(negedge clk);
        ce = cev;
        #1;
        s_addr = rom_addr; s_do = cart_do; s_sel = cart_sel;
        @(posedge clk);
        #1 ce = 1'b0;
        s_bank = bank;
    endtask

    task automatic rst_access(input logic [12:0] aa, input logic rr, input logic [7:0] dd,
                              input logic [2:0] mp, input logic sc);
        @(negedge clk);
        a = aa; r = rr; d_in = dd; ce = 1'b0;
        @(negedge clk);
        ce = 1'b1; rst = 1'b1; mapper = mp; sc_en = sc;
        @(posedge clk);
        #1 ce = 1'b0; rst = 1'b0;
        s_bank = bank;
    endtask

    // Reference model: state kept as plain integers, mapping computed arithmetically.
    int         m_mode, m_bank;
    bit         m_sc;
    int         m_sl[4];
    logic [7:0] m_ram[128];
    bit         m_val[128];

    function automatic void model_reset(input int mp, input bit sc);
        m_mode = (mp > 5) ? 0 : mp;
        m_sc   = sc;
        m_bank = (m_mode == 1) ? 1 : (m_mode == 2) ? 3 : (m_mode == 3) ? 7 : 0;
        m_sl   = '{4, 5, 6, 7};
    endfunction

    function automatic int model_addr(input int aa);
        int lo = aa % 4096;
        case (m_mode)
            1, 2, 3: return m_bank * 4096 + lo;
            4:       return m_sl[(aa / 1024) % 4] * 1024 + aa % 1024;
            5:       return ((aa % 4096) >= 2048) ? 3 * 2048 + aa % 2048 : m_bank * 2048 + aa % 2048;
            default: return lo;
        endcase
    endfunction

    function automatic int model_bank();
        if (m_mode == 4) return m_sl[0];
        if (m_mode == 0) return 0;
        return m_bank;
    endfunction

    function automatic bit model_sc();
        return m_sc && m_mode >= 1 && m_mode <= 3;
    endfunction

    function automatic void model_update(input int aa, input bit rr, input int dd);
        case (m_mode)
            1: if (aa >= 'h1FF8 && aa <= 'h1FF9) m_bank = aa - 'h1FF8;
            2: if (aa >= 'h1FF6 && aa <= 'h1FF9) m_bank = aa - 'h1FF6;
            3: if (aa >= 'h1FF4 && aa <= 'h1FFB) m_bank = aa - 'h1FF4;
            4: if (aa >= 'h1FE0 && aa <= 'h1FF7) m_sl[(aa - 'h1FE0) / 8] = aa % 8;
            5: if (!rr && aa < 'h40) m_bank = dd % 4;
            default: ;
        endcase
        if (model_sc() && !rr && aa >= 'h1000 && aa <= 'h107F) begin
            m_ram[aa - 'h1000] = 8'(dd);
            m_val[aa - 'h1000] = 1'b1;
        end
    endfunction

    typedef struct {
        bit          rst;
        logic [2:0]  mapper;
        logic [12:0] a;
        bit          r;
        logic [7:0]  d;
        bit          ce;
        logic [14:0] exp_addr;
        int          exp_do;     // -1: expect rom_f(exp_addr)
        logic [2:0]  exp_bank;
    } vec_t;

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{1, 3'd1, 13'h1FFC, 1, 8'h00, 1, 15'h1FFC, -1,    3'd1};
        vecs[1]  = '{0, 3'd1, 13'h1FF8, 1, 8'h00, 1, 15'h1FF8, -1,    3'd0};
        vecs[2]  = '{0, 3'd1, 13'h1000, 1, 8'h00, 0, 15'h0000, -1,    3'd0};
        vecs[3]  = '{1, 3'd3, 13'h1FF4, 1, 8'h00, 1, 15'h7FF4, -1,    3'd0};
        vecs[4]  = '{0, 3'd3, 13'h1123, 1, 8'h00, 1, 15'h0123, -1,    3'd0};
        vecs[5]  = '{0, 3'd3, 13'h1FF9, 1, 8'h00, 0, 15'h0FF9, -1,    3'd0};
        vecs[6]  = '{0, 3'd3, 13'h1FFB, 0, 8'h00, 1, 15'h0FFB, -1,    3'd7};
        vecs[7]  = '{0, 3'd3, 13'h1123, 1, 8'h00, 0, 15'h7123, -1,    3'd7};
        vecs[8]  = '{1, 3'd4, 13'h1FE9, 1, 8'h00, 1, 15'h1FE9, -1,    3'd4};
        vecs[9]  = '{0, 3'd4, 13'h1FF2, 1, 8'h00, 1, 15'h1FF2, -1,    3'd4};
        vecs[10] = '{0, 3'd4, 13'h1400, 1, 8'h00, 0, 15'h0400, -1,    3'd4};
        vecs[11] = '{0, 3'd4, 13'h1C05, 1, 8'h00, 0, 15'h1C05, -1,    3'd4};
        vecs[12] = '{0, 3'd4, 13'h1000, 1, 8'h00, 0, 15'h1000, -1,    3'd4};
        vecs[13] = '{0, 3'd4, 13'h1800, 1, 8'h00, 0, 15'h0800, -1,    3'd4};
        vecs[14] = '{1, 3'd5, 13'h003F, 0, 8'h02, 1, 15'h003F, 'hFF,  3'd2};
        vecs[15] = '{0, 3'd5, 13'h1234, 1, 8'h00, 0, 15'h1234, -1,    3'd2};
        vecs[16] = '{0, 3'd5, 13'h003F, 1, 8'h01, 1, 15'h103F, 'hFF,  3'd2};
        vecs[17] = '{0, 3'd5, 13'h1800, 1, 8'h00, 0, 15'h1800, -1,    3'd2};
        vecs[18] = '{1, 3'd7, 13'h1FF8, 1, 8'h00, 1, 15'h0FF8, -1,    3'd0};
        vecs[19] = '{1, 3'd2, 13'h1FF7, 1, 8'h00, 1, 15'h3FF7, -1,    3'd1};

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].rst) do_reset(vecs[i].mapper, 1'b0);
            access(vecs[i].a, vecs[i].r, vecs[i].d, vecs[i].ce);
            chk($sformatf("vec%0d_rom_addr", i), s_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_cart_do", i), s_do,
                (vecs[i].exp_do < 0) ? rom_f(vecs[i].exp_addr) : vecs[i].exp_do);
            chk($sformatf("vec%0d_bank", i), s_bank, vecs[i].exp_bank);
        end

        // SuperChip on F8
        do_reset(3'd1, 1'b1);
        access(13'h1005, 1'b0, 8'hA5, 1'b1);
        chk("sc_write_port_do", s_do, rom_f(15'h1005));
        access(13'h1085, 1'b1, 8'h00, 1'b1);
        chk("sc_read", s_do, 'hA5);
        access(13'h1005, 1'b1, 8'h00, 1'b1);
        chk("sc_wport_read_do", s_do, rom_f(15'h1005));
        access(13'h1085, 1'b1, 8'h00, 1'b1);
        chk("sc_read_unchanged", s_do, 'hA5);
        access(13'h0080, 1'b1, 8'h00, 1'b1);
        chk("unsel_do", s_do, 'hFF);
        chk("unsel_sel", s_sel, 0);

        // mapper input changed without reset: still F8
        mapper = 3'd3;
        access(13'h1FF4, 1'b1, 8'h00, 1'b1);
        chk("latched_no_f4_hit", s_bank, 1);
        access(13'h1FF8, 1'b1, 8'h00, 1'b1);
        chk("latched_f8_hit", s_bank, 0);

        // reset coincident with a hotspot and with a SuperChip write
        rst_access(13'h1FF7, 1'b1, 8'h00, 3'd2, 1'b1);
        chk("rst_wins_hotspot", s_bank, 3);
        rst_access(13'h1005, 1'b0, 8'h5A, 3'd2, 1'b1);
        chk("rst_bank_after_sc_wr", s_bank, 3);
        access(13'h1085, 1'b1, 8'h00, 1'b0);
        chk("ram_kept_no_rst_write", s_do, 'hA5);
        chk("ram_kept_addr_sel", s_sel, 1);

        // Random traffic against the model
        for (int i = 0; i < 128; i++) m_val[i] = 1'b0;
        for (int rs = 0; rs < 10; rs++) begin
            int mp;
            bit sc;
            mp = $urandom_range(0, 7);
            sc = $urandom_range(0, 1);
            do_reset(3'(mp), sc);
            model_reset(mp, sc);
            chk("rnd_reset_bank", bank, model_bank());
            for (int k = 0; k < 80; k++) begin
                int  aa, dd, cat, exp_do;
                bit  rr, cev, known;
                cat = $urandom_range(0, 5);
                case (cat)
                    1:       aa = 'h1FE0 + $urandom_range(0, 31);
                    2:       aa = 'h1000 + $urandom_range(0, 255);
                    3:       aa = $urandom_range(0, 'h7F);
                    default: aa = $urandom_range(0, 'h1FFF);
                endcase
                rr  = $urandom_range(0, 1);
                dd  = $urandom_range(0, 255);
                cev = ($urandom_range(0, 3) != 0);
                access(13'(aa), rr, 8'(dd), cev);
                known = 1'b1;
                if (aa < 'h1000) exp_do = 'hFF;
                else if (model_sc() && aa >= 'h1080 && aa <= 'h10FF) begin
                    known  = m_val[aa - 'h1080];
                    exp_do = m_ram[aa - 'h1080];
                end else exp_do = rom_f(15'(model_addr(aa)));
                chk("rnd_rom_addr", s_addr, model_addr(aa));
                chk("rnd_cart_sel", s_sel, (aa >= 'h1000) ? 1 : 0);
                if (known) chk("rnd_cart_do", s_do, exp_do);
                if (cev) model_update(aa, rr, dd);
                chk("rnd_bank", s_bank, model_bank());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
